button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Front-end input stage for the stopwatch: takes raw, bouncing, asynchronous push-button/switch lines (start, stop, lap, clr, TimeSet) and turns them into clean signals for the stopwatch core.
- For each line it synchronises, debounces, and emits a debounced level plus single-cycle press, release and auto-repeat pulses.
- Sits directly upstream of the stopwatch core; the core consumes only the outputs of this block, never the raw pins.

Parameters:
- NUM_BTN, 5, number of independent input lines conditioned in parallel (bit i of every bus belongs to button i).
- DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles needed to accept a press or release (10 ms at 100 MHz); minimum 2.
- HOLD_CYCLES, 50000000, cycles a button must stay accepted-pressed before auto-repeat starts (0.5 s); minimum 2.
- REPEAT_CYCLES, 10000000, period of auto-repeat pulses once holding (0.1 s); minimum 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn_raw  input  NUM_BTN  raw pin levels, asynchronous to clk, active-high.
- btn_level  output  NUM_BTN  debounced level.
- btn_press  output  NUM_BTN  one-cycle pulse on an accepted press.
- btn_release  output  NUM_BTN  one-cycle pulse on an accepted release.
- btn_repeat  output  NUM_BTN  one-cycle auto-repeat pulses while held.
- any_press  output  1  OR of all btn_press bits, same cycle.

Behaviour:
- Reset: one clock (clk); reset (rst) is asynchronous and active-high.
  - Asserting rst immediately forces every output, every synchroniser flop, every counter and every FSM to 0 / IDLE.
  - This holds mid-operation too. A pulse in flight is dropped, not completed.
- Synchroniser: two flops per bit, reset to 0. The FSM sees only the output of the second flop (sync).
- Per-button FSM and counter:
  - Each button has its own FSM and its own counter.
  - Counter width is clog2 of max(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES).
  - The counter clears on every state transition.
- FSM states and transitions:
  - IDLE: level=0. If sync=1, go to ARM.
  - ARM: the counter increments while sync=1.
    - If sync=0, go back to IDLE; the bounce is rejected with no pulse.
    - When the counter reaches DEBOUNCE_CYCLES-1 with sync=1, go to PRESSED. btn_press=1 for that single cycle, and btn_level rises on the same cycle.
  - PRESSED: level=1. The counter increments while sync=1.
    - If sync=0, go to DISARM.
    - When the counter reaches HOLD_CYCLES-1, go to REPEAT and pulse btn_repeat once.
  - REPEAT: level=1.
    - Pulse btn_repeat every REPEAT_CYCLES cycles, i.e. when the counter reaches REPEAT_CYCLES-1, then the counter wraps to 0.
    - If sync=0, go to DISARM.
  - DISARM: level stays 1. The counter increments while sync=0.
    - If sync=1, go to PRESSED. Hold timing restarts and no new press pulse is generated.
    - When the counter reaches DEBOUNCE_CYCLES-1, go to IDLE. btn_release=1 for one cycle, and btn_level falls on the same cycle.
- Latency: a clean raw edge, stable thereafter, produces btn_press / btn_release exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new raw value.
  - First btn_repeat comes HOLD_CYCLES cycles after btn_press; subsequent repeats come every REPEAT_CYCLES cycles.
- Pulse exclusivity: press, release and repeat are mutually exclusive per button, never two in one cycle. Every press is eventually paired with exactly one release unless rst intervenes.
- Independence: buttons are fully independent. Simultaneous presses on several buttons produce their pulses in the same cycle, and any_press is 1 for that cycle only.
- Held through reset: a button held while rst deasserts is treated as a new press. It is debounced from IDLE and gives btn_press DEBOUNCE_CYCLES+2 cycles after rst falls.
- Glitch rejection: a raw glitch shorter than DEBOUNCE_CYCLES cycles never changes btn_level and produces no pulse.
- All outputs are registered; no combinational path from btn_raw to any output.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, NUM_BTN=5.
1. Clean press: btn_raw[0] 0→1, held 40 cycles → btn_press[0] pulses at cycle 6; btn_repeat[0] at cycles 26 and 34; btn_level[0]=1 from cycle 6.
2. Clean release: after scenario 1, btn_raw[0] 1→0 → btn_release[0] one cycle at release+6; btn_level[0]=0 on that cycle; no further repeats.
3. Bounce rejection: btn_raw[1] toggles 1,0,1,0 on single cycles, then stays 0 → no pulses; btn_level[1] stays 0.
   Then 3 cycles high, then low → still no pulses.
4. Release bounce: while PRESSED, btn_raw[2] drops for 2 cycles, then returns → no release and no second press.
   btn_repeat[2] first fires 20 cycles after the return, not 20 after the original press.
5. Simultaneous press: btn_raw[3] and btn_raw[4] rise together → both btn_press bits pulse in the same cycle (6); any_press=1 for exactly that one cycle.
6. Reset mid-hold: btn_raw[0] held and in REPEAT, rst pulsed for 3 cycles → all outputs 0 immediately while rst=1.
   After rst falls, btn_press[0] pulses 6 cycles later.

Source files
------------

// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - button conditioner pin/pulse bundle
//
// Purpose: groups the raw button lines and the conditioned outputs of
// button_conditioner into one bundle.
// Signals (bit i of every bus belongs to button i):
//   btn_raw     raw asynchronous pin levels, active-high
//   btn_level   debounced level
//   btn_press   one-cycle pulse on an accepted press
//   btn_release one-cycle pulse on an accepted release
//   btn_repeat  one-cycle auto-repeat pulses while held
//   any_press   OR of all btn_press bits, same cycle
// Modports: master = conditioner side, slave = consumer/pin side.
interface button_conditioner_if #(
    parameter int NUM_BTN = 5
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic [NUM_BTN-1:0] btn_repeat;
    logic               any_press;

    modport master (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_repeat,
        output any_press
    );

    modport slave (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_repeat,
        input  any_press
    );
endinterface

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronise, debounce and pulse-encode button lines
//
// Purpose: per button, a two-flop synchroniser feeds a debounce/hold FSM
// that produces a clean level plus single-cycle press, release and
// auto-repeat pulses. All outputs are registered.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  button_conditioner_if.master (btn_raw in; level/press/release/
//        repeat/any_press out)
module button_conditioner #(
    parameter int NUM_BTN         = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic                        clk,
    input  logic                        rst,
    button_conditioner_if.master        bus
);

    localparam int MAX_DH  = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_CYC = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        PRESSED = 3'd2,
        REPEAT  = 3'd3,
        DISARM  = 3'd4
    } state_t;

    logic [NUM_BTN-1:0] meta_q;
    logic [NUM_BTN-1:0] sync_q;

    logic [NUM_BTN-1:0] level_vec;
    logic [NUM_BTN-1:0] press_vec;
    logic [NUM_BTN-1:0] release_vec;
    logic [NUM_BTN-1:0] repeat_vec;
    logic [NUM_BTN-1:0] press_nxt;
    logic               any_press_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= bus.btn_raw;
            sync_q <= meta_q;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d;
        logic             press_q, press_d;
        logic             release_q, release_d;
        logic             repeat_q, repeat_d;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                repeat_q  <= repeat_d;
            end
        end

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q + CNT_W'(1);
            press_d   = 1'b0;
            release_d = 1'b0;
            repeat_d  = 1'b0;
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (sync_q[i]) state_d = ARM;
                end
                ARM: begin
                    if (!sync_q[i]) begin
                        state_d = IDLE;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d = PRESSED;
                        press_d = 1'b1;
                    end
                end
                PRESSED: begin
                    if (!sync_q[i]) begin
                        state_d = DISARM;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d  = REPEAT;
                        repeat_d = 1'b1;
                    end
                end
                REPEAT: begin
                    if (!sync_q[i]) begin
                        state_d = DISARM;
                    end else if (cnt_q == REP_LAST) begin
                        repeat_d = 1'b1;
                        cnt_d    = '0;
                    end
                end
                DISARM: begin
                    // A return to 1 re-enters PRESSED without a new press pulse;
                    // hold timing restarts from that point.
                    if (sync_q[i]) begin
                        state_d = PRESSED;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d   = IDLE;
                        release_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
            if (state_d != state_q) cnt_d = '0;
            // Level follows the next state so it changes on the same cycle
            // as the press/release pulse.
            level_d = (state_d == PRESSED) || (state_d == REPEAT) || (state_d == DISARM);
        end

        assign level_vec[i]   = level_q;
        assign press_vec[i]   = press_q;
        assign release_vec[i] = release_q;
        assign repeat_vec[i]  = repeat_q;
        assign press_nxt[i]   = press_d;
    end

    // Registered from the next-state press bits so it lines up with btn_press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= |press_nxt;
        end
    end

    assign bus.btn_level   = level_vec;
    assign bus.btn_press   = press_vec;
    assign bus.btn_release = release_vec;
    assign bus.btn_repeat  = repeat_vec;
    assign bus.any_press   = any_press_q;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - self-checking bench for button_conditioner
module tb_button_conditioner;

    localparam int NB = 5;
    localparam int D  = 4;
    localparam int H  = 20;
    localparam int R  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    button_conditioner_if #(.NUM_BTN(NB)) bus ();

    button_conditioner #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int            cyc;
        logic [NB-1:0] p;
        logic [NB-1:0] r;
        logic [NB-1:0] t;
    } ev_t;

    ev_t exp_q[$];

    int n_total = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: acceptance is decided by the length of the run of
    // identical synchronised values; repeats by elapsed time from the hold anchor.
    logic [NB-1:0] s1     = '0;
    logic [NB-1:0] s2     = '0;
    logic [NB-1:0] last   = '0;
    logic [NB-1:0] mlevel = '0;
    logic          m_any  = 1'b0;
    int            run    [NB];
    int            anchor [NB];

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        logic [NB-1:0] p, r, t;
        logic seen;
        cyc++;
        p = '0; r = '0; t = '0;
        if (rst) begin
            s1 = '0; s2 = '0; last = '0; mlevel = '0; m_any = 1'b0;
            for (int b = 0; b < NB; b++) begin
                run[b] = 0;
                anchor[b] = 0;
            end
            return;
        end
        for (int b = 0; b < NB; b++) begin
            seen = s2[b];
            if (seen == last[b]) run[b]++;
            else run[b] = 1;
            last[b] = seen;
            if (!mlevel[b]) begin
                if (seen && run[b] == D + 1) begin
                    p[b] = 1'b1;
                    mlevel[b] = 1'b1;
                    anchor[b] = cyc;
                end
            end else if (!seen) begin
                if (run[b] == D + 1) begin
                    r[b] = 1'b1;
                    mlevel[b] = 1'b0;
                end
            end else begin
                if (run[b] == 1) anchor[b] = cyc;
                else if ((cyc - anchor[b]) >= H && ((cyc - anchor[b] - H) % R) == 0) t[b] = 1'b1;
            end
        end
        m_any = |p;
        if ((p | r | t) != '0) exp_q.push_back('{cyc: cyc, p: p, r: r, t: t});
        s2 = s1;
        s1 = bus.btn_raw;
    endtask

    task automatic monitor_step();
        ev_t e;
        logic [NB-1:0] dp, dr, dt;
        dp = bus.btn_press; dr = bus.btn_release; dt = bus.btn_repeat;
        if (rst) begin
            chk({bus.btn_level, dp, dr, dt, bus.any_press} == '0, "rst_outputs_zero",
                32'({bus.btn_level, dp, dr, dt, bus.any_press}), 32'd0);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) void'(exp_q.pop_front());
            return;
        end
        chk(bus.btn_level == mlevel, "level", 32'(bus.btn_level), 32'(mlevel));
        chk(bus.any_press == m_any, "any_press", 32'(bus.any_press), 32'(m_any));
        if ((dp | dr | dt) != '0 || (exp_q.size() > 0 && exp_q[0].cyc <= cyc)) begin
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_pulse", 32'({dp, dr, dt}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk(e.cyc == cyc, "pulse_cycle", 32'(cyc), 32'(e.cyc));
                chk(dp == e.p, "press", 32'(dp), 32'(e.p));
                chk(dr == e.r, "release", 32'(dr), 32'(e.r));
                chk(dt == e.t, "repeat", 32'(dt), 32'(e.t));
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        monitor_step();
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_bit(input int b, input logic v);
        logic [NB-1:0] tmp;
        tmp = bus.btn_raw;
        tmp[b] = v;
        bus.btn_raw = tmp;
    endtask

    initial begin
        logic [NB-1:0] mask;
        bus.btn_raw = '0;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(3);

        // Clean press held into repeat, then clean release
        set_bit(0, 1'b1); step(40);
        set_bit(0, 1'b0); step(15);

        // Bounce rejection: single-cycle toggles, then a 3-cycle pulse
        set_bit(1, 1'b1); step(1); set_bit(1, 1'b0); step(1);
        set_bit(1, 1'b1); step(1); set_bit(1, 1'b0); step(10);
        set_bit(1, 1'b1); step(3); set_bit(1, 1'b0); step(10);

        // Release bounce while pressed: hold timing restarts on return
        set_bit(2, 1'b1); step(12);
        set_bit(2, 1'b0); step(2);
        set_bit(2, 1'b1); step(35);
        set_bit(2, 1'b0); step(12);

        // Simultaneous press on two buttons
        set_bit(3, 1'b1); set_bit(4, 1'b1); step(10);
        set_bit(3, 1'b0); set_bit(4, 1'b0); step(12);

        // Reset while holding in repeat, button still held after reset
        set_bit(0, 1'b1); step(35);
        rst = 1'b1; step(3);
        rst = 1'b0; step(15);
        set_bit(0, 1'b0); step(12);

        // Randomized activity with occasional long holds and resets
        repeat (250) begin
            mask = NB'($urandom & $urandom);
            bus.btn_raw = bus.btn_raw ^ mask;
            if ($urandom_range(0, 5) == 0) step($urandom_range(20, 45));
            else step($urandom_range(1, 10));
            if ($urandom_range(0, 60) == 0) begin
                rst = 1'b1; step($urandom_range(1, 3));
                rst = 1'b0;
            end
        end

        bus.btn_raw = '0;
        step(20);
        chk(exp_q.size() == 0, "expected_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
